// File: rtl/riscv_ifq.sv
// riscv_ifq: instruction fetch queue between the IFU (producer) and IDU (consumer).
// Buffers fetched instruction words with their PC and sequence number in a small
// circular FIFO. Flush from execute discards all buffered instructions.
//
// Ports:
//   clock, reset      core clock, synchronous active-high reset
//   flush             pipeline flush, empties the queue (reset has priority)
//   in_vld / in_rdy   producer handshake; in_rdy depends only on occupancy
//   in_addr/inst/seq  pushed payload (PC, instruction word, sequence number)
//   out_vld / out_rdy consumer handshake for the head entry
//   out_addr/inst/seq head payload, driven from the entry at the read pointer
//   count             current occupancy, 0..DEPTH

package riscv_ifq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned SEQ_W  = 64;

    // One queued instruction.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
        logic [SEQ_W-1:0]  seq;
    } ifq_entry_t;

endpackage

module riscv_ifq
    import riscv_ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [INST_W-1:0]             in_inst,
    input  logic [SEQ_W-1:0]              in_seq,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [INST_W-1:0]             out_inst,
    output logic [SEQ_W-1:0]              out_seq,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Storage and state.
    ifq_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   out_vld_q, out_vld_d;
    logic                   in_rdy_q, in_rdy_d;

    logic                   push_c;
    logic                   pop_c;
    ifq_entry_t             entry_in_c;
    ifq_entry_t             head_c;

    // Handshake qualification; flush suppresses both sides in the same cycle.
    assign push_c = in_vld && in_rdy_q && !flush;
    assign pop_c  = out_vld_q && out_rdy && !flush;

    assign entry_in_c = '{addr: in_addr, inst: in_inst, seq: in_seq};

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        out_vld_d = out_vld_q;
        in_rdy_d  = in_rdy_q;

        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
            in_rdy_d  = 1'b1;
        end else begin
            if (push_c) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            out_vld_d = (count_d != '0);
            in_rdy_d  = (count_d != CNT_W'(DEPTH));
        end
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    // Payload storage; cleared only by reset so the idle head reads zero after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (push_c) begin
            mem_q[wptr_q] <= entry_in_c;
        end
    end

    // Head entry is selected purely from state, so in_* never reach out_* combinationally.
    assign head_c   = mem_q[rptr_q];

    assign out_addr = head_c.addr;
    assign out_inst = head_c.inst;
    assign out_seq  = head_c.seq;
    assign out_vld  = out_vld_q;
    assign in_rdy   = in_rdy_q;
    assign count    = count_q;

endmodule
